store_process: RTL and testbench

- Store-side counterpart of the load-data extension path.
- Takes a store (sb/sh/sw) from the MEM stage and checks alignment.
- Replicates rs2 data across byte lanes and builds a 4-bit write strobe.
- Queues each store in a small in-order write buffer, then drains it to the data cache/memory over a req/ack handshake, so the pipeline stalls only when the buffer is full.

---
 rtl/store_process.sv | 152 +++++++++++++++
 tb/tb_store_process.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_process.sv
// store_process: store-side formatting and in-order write buffer.
// Stores from the MEM stage are alignment-checked, lane-replicated and
// given a byte strobe, then queued and drained to memory over req/ack.
// The pipeline only stalls when the buffer is full.

module store_process #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [31:0]   st_addr,
    input  logic [31:0]   st_data,
    input  logic [2:0]    functM,
    output logic          misalign,
    output logic          mem_req,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    input  logic          mem_ack,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [3:0]    strb_q [DEPTH];

    logic          push;
    logic          pop;
    logic [31:0]   fmt_addr;
    logic [31:0]   fmt_data;
    logic [3:0]    fmt_strb;

    // Flag stores whose width/offset combination cannot be written as one aligned word access.
    always_comb begin
        misalign = 1'b0;
        if (st_valid) begin
            case (functM)
                3'b000:  misalign = 1'b0;
                3'b001:  misalign = st_addr[0];
                3'b010:  misalign = |st_addr[1:0];
                default: misalign = 1'b1;
            endcase
        end
    end

    // Replicate the store data across lanes and build the byte strobe before it enters the buffer.
    always_comb begin
        fmt_addr = {st_addr[31:2], 2'b00};
        fmt_data = st_data;
        fmt_strb = 4'b1111;
        case (functM)
            3'b000: begin
                fmt_data = {4{st_data[7:0]}};
                fmt_strb = 4'b0001 << st_addr[1:0];
            end
            3'b001: begin
                fmt_data = {2{st_data[15:0]}};
                fmt_strb = 4'b0011 << st_addr[1:0];
            end
            default: begin
                fmt_data = st_data;
                fmt_strb = 4'b1111;
            end
        endcase
    end

    // A full buffer refuses stores even when the head is leaving this cycle; there is no pass-through path.
    assign st_ready = (count != FULL_COUNT);
    assign empty    = (count == '0);
    assign push     = st_valid && st_ready && !misalign;
    assign pop      = (state == REQ) && mem_ack;

    // The head entry is only shown while a request is active so the bus reads zero when idle.
    assign mem_req   = (state == REQ);
    assign mem_addr  = mem_req ? addr_q[rd_ptr] : 32'h0;
    assign mem_wdata = mem_req ? data_q[rd_ptr] : 32'h0;
    assign mem_wstrb = mem_req ? strb_q[rd_ptr] : 4'h0;

    // Write the formatted store into the tail slot; reset wipes every slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= 32'h0;
                data_q[i] <= 32'h0;
                strb_q[i] <= 4'h0;
            end
        end else if (push) begin
            addr_q[wr_ptr] <= fmt_addr;
            data_q[wr_ptr] <= fmt_data;
            strb_q[wr_ptr] <= fmt_strb;
        end
    end

    // Pointers advance independently and wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Drain FSM: stay in REQ while anything remains after this cycle's pop and push.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0 || push) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (pop && count == CW'(1) && !push) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_process.sv
// tb_store_process: directed vector table for formatting/misalign plus
// hand sequences for backpressure, pointer wrap and mid-drain reset.

module tb_store_process;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          st_valid;
    logic          st_ready;
    logic [31:0]   st_addr;
    logic [31:0]   st_data;
    logic [2:0]    functM;
    logic          misalign;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ack;
    logic          empty;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    store_process #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .functM    (functM),
        .misalign  (misalign),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ack   (mem_ack),
        .empty     (empty),
        .count     (count)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  funct;
        logic        ack;
        logic        exp_mis;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_strb;
        logic [2:0]  exp_count;
    } vec_t;

    vec_t vecs [11];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic valid, input logic [31:0] addr, input logic [31:0] data,
                         input logic [2:0] funct, input logic ack);
        st_valid = valid;
        st_addr  = addr;
        st_data  = data;
        functM   = funct;
        mem_ack  = ack;
    endtask

    // Drive one vector at the falling edge, check misalign before the rising edge, then the registered view after it.
    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        drive(v.valid, v.addr, v.data, v.funct, v.ack);
        #1;
        checkOutput($sformatf("vec%0d misalign", idx), 32'(misalign), 32'(v.exp_mis));
        @(posedge clk);
        #1;
        checkOutput($sformatf("vec%0d mem_req", idx), 32'(mem_req), 32'(v.exp_req));
        checkOutput($sformatf("vec%0d mem_addr", idx), mem_addr, v.exp_addr);
        checkOutput($sformatf("vec%0d mem_wdata", idx), mem_wdata, v.exp_wdata);
        checkOutput($sformatf("vec%0d mem_wstrb", idx), 32'(mem_wstrb), 32'(v.exp_strb));
        checkOutput($sformatf("vec%0d count", idx), 32'(count), 32'(v.exp_count));
        checkOutput($sformatf("vec%0d st_ready", idx), 32'(st_ready), 32'(v.exp_count != 3'd4));
        checkOutput($sformatf("vec%0d empty", idx), 32'(empty), 32'(v.exp_count == 3'd0));
    endtask

    // Stimulus sequence: reset, vector table, then multi-cycle corner cases.
    initial begin
        logic [31:0] w_addr [10];
        logic [31:0] w_data [10];
        logic [2:0]  w_funct [10];
        logic [31:0] e_wdata [10];
        logic [3:0]  e_strb [10];

        //          valid addr          data          funct   ack  mis  req  exp_addr      exp_wdata     strb     cnt
        vecs[0]  = '{1'b1, 32'h0000_1003, 32'h1234_5678, 3'b000, 1'b1, 1'b0, 1'b1, 32'h0000_1000, 32'h7878_7878, 4'b1000, 3'd1};
        vecs[1]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         4'b0000, 3'd0};
        vecs[2]  = '{1'b1, 32'h0000_2002, 32'hAABB_CCDD, 3'b001, 1'b1, 1'b0, 1'b1, 32'h0000_2000, 32'hCCDD_CCDD, 4'b1100, 3'd1};
        vecs[3]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         4'b0000, 3'd0};
        vecs[4]  = '{1'b1, 32'h0000_2001, 32'hAABB_CCDD, 3'b001, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0,         4'b0000, 3'd0};
        vecs[5]  = '{1'b1, 32'h0000_3006, 32'h1111_2222, 3'b010, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0,         4'b0000, 3'd0};
        vecs[6]  = '{1'b1, 32'h0000_4000, 32'h3333_4444, 3'b011, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0,         4'b0000, 3'd0};
        vecs[7]  = '{1'b1, 32'h0000_4000, 32'hDEAD_BEEF, 3'b010, 1'b1, 1'b0, 1'b1, 32'h0000_4000, 32'hDEAD_BEEF, 4'b1111, 3'd1};
        vecs[8]  = '{1'b1, 32'h0000_5001, 32'h0000_00A5, 3'b000, 1'b1, 1'b0, 1'b1, 32'h0000_5000, 32'hA5A5_A5A5, 4'b0010, 3'd1};
        vecs[9]  = '{1'b1, 32'h0000_5000, 32'h0000_1234, 3'b001, 1'b1, 1'b0, 1'b1, 32'h0000_5000, 32'h1234_1234, 4'b0011, 3'd1};
        vecs[10] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 3'b011, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         4'b0000, 3'd0};

        // Reset for two cycles, then confirm the idle state.
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset mem_req", 32'(mem_req), 32'h0);
        checkOutput("reset st_ready", 32'(st_ready), 32'h1);
        checkOutput("reset empty", 32'(empty), 32'h1);
        checkOutput("reset count", 32'(count), 32'h0);
        checkOutput("reset mem_wstrb", 32'(mem_wstrb), 32'h0);
        checkOutput("reset mem_addr", mem_addr, 32'h0);
        checkOutput("reset mem_wdata", mem_wdata, 32'h0);
        checkOutput("reset misalign", 32'(misalign), 32'h0);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Backpressure: five stores with no ack, only four fit.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b1, 32'h0000_0100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 3'b010, 1'b0);
            #1;
            if (i == 4) begin
                checkOutput("full st_ready before 5th", 32'(st_ready), 32'h0);
            end
            @(posedge clk);
            #1;
            checkOutput($sformatf("full count after push %0d", i), 32'(count), (i < 4) ? 32'(i + 1) : 32'd4);
            checkOutput($sformatf("full head addr after push %0d", i), mem_addr, 32'h0000_0100);
            checkOutput($sformatf("full mem_req after push %0d", i), 32'(mem_req), 32'h1);
        end
        checkOutput("full st_ready", 32'(st_ready), 32'h0);

        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("single pop count", 32'(count), 32'd3);
        checkOutput("single pop st_ready", 32'(st_ready), 32'h1);
        checkOutput("single pop next addr", mem_addr, 32'h0000_0104);
        checkOutput("single pop next wdata", mem_wdata, 32'hA000_0001);

        @(negedge clk);
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("hold head addr", mem_addr, 32'h0000_0104);
        checkOutput("hold count", 32'(count), 32'd3);

        for (int j = 1; j < 4; j++) begin
            @(negedge clk);
            mem_ack = 1'b1;
            #1;
            checkOutput($sformatf("drain order addr %0d", j), mem_addr, 32'h0000_0100 + 32'(4 * j));
            checkOutput($sformatf("drain order wdata %0d", j), mem_wdata, 32'hA000_0000 + 32'(j));
            @(posedge clk);
        end
        #1;
        checkOutput("drained mem_req", 32'(mem_req), 32'h0);
        checkOutput("drained empty", 32'(empty), 32'h1);

        // Ten back-to-back stores with ack every cycle, mixing sw and sb so the pointers wrap.
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) begin
                w_addr[k]  = 32'h0000_8000 + 32'(8 * k);
                w_data[k]  = 32'h1111_0000 + 32'(k);
                w_funct[k] = 3'b010;
                e_wdata[k] = w_data[k];
                e_strb[k]  = 4'b1111;
            end else begin
                w_addr[k]  = 32'h0000_8000 + 32'(8 * k) + 32'd1;
                w_data[k]  = 32'(k * 17);
                w_funct[k] = 3'b000;
                e_wdata[k] = {4{w_data[k][7:0]}};
                e_strb[k]  = 4'b0010;
            end
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            drive(1'b1, w_addr[k], w_data[k], w_funct[k], 1'b1);
            #1;
            if (k > 0) begin
                checkOutput($sformatf("wrap addr %0d", k - 1), mem_addr, {w_addr[k - 1][31:2], 2'b00});
                checkOutput($sformatf("wrap wdata %0d", k - 1), mem_wdata, e_wdata[k - 1]);
                checkOutput($sformatf("wrap wstrb %0d", k - 1), 32'(mem_wstrb), 32'(e_strb[k - 1]));
                checkOutput($sformatf("wrap count %0d", k - 1), 32'(count), 32'd1);
            end
            @(posedge clk);
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
        #1;
        checkOutput("wrap addr 9", mem_addr, {w_addr[9][31:2], 2'b00});
        checkOutput("wrap wdata 9", mem_wdata, e_wdata[9]);
        @(posedge clk);
        #1;
        checkOutput("wrap done mem_req", 32'(mem_req), 32'h0);
        checkOutput("wrap done count", 32'(count), 32'h0);

        // Reset in the middle of a drain discards everything queued.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 32'h0000_9000 + 32'(4 * i), 32'h5500_0000 + 32'(i), 3'b010, 1'b0);
            @(posedge clk);
        end
        #1;
        checkOutput("pre-reset count", 32'(count), 32'd3);
        checkOutput("pre-reset mem_req", 32'(mem_req), 32'h1);
        checkOutput("pre-reset addr", mem_addr, 32'h0000_9000);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid reset mem_req", 32'(mem_req), 32'h0);
        checkOutput("mid reset count", 32'(count), 32'h0);
        checkOutput("mid reset empty", 32'(empty), 32'h1);
        checkOutput("mid reset st_ready", 32'(st_ready), 32'h1);
        checkOutput("mid reset mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("post reset mem_req %0d", i), 32'(mem_req), 32'h0);
            checkOutput($sformatf("post reset count %0d", i), 32'(count), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
